decimal_key_debouncer: RTL
==========================

// Module: decimal_key_debouncer
// PURPOSE
//  Front end of the decimal entry path: takes 10 raw, bouncy, asynchronous key lines (keys 0-9),
//  synchronises and debounces them and emits a clean one-hot decimal vector d_out[9:0] for the
//  decimal-to-binary encoder directly downstream. Adds a one-cycle new-key strobe and rejects
//  simultaneous presses, so the encoder only ever sees zero or exactly one active line.
// PARAMETERS
//  DEBOUNCE_CYCLES  16                          consecutive stable samples needed to accept press/release (>=2)
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)   debounce counter width (derived, do not override)
// PORTS
//  clk         in   1   single clock, all logic on rising edge
//  reset       in   1   synchronous, active-high reset
//  key_in      in   10  raw key lines, bit i = key i, active-high, asynchronous to clk
//  d_out       out  10  debounced one-hot decimal, bit i drives encoder input d<i>; all-zero = no key
//  key_valid   out  1   high while d_out holds an accepted key
//  key_strobe  out  1   one-cycle pulse on the cycle d_out first shows a newly accepted key
//  multi_err   out  1   one-cycle pulse when a debounced multi-key pattern is rejected
// BEHAVIOUR
//  - Reset (sync, active-high): d_out=0, key_valid=0, key_strobe=0, multi_err=0, state=IDLE,
//    counter=0, candidate=0, synchroniser flops=0. Reset mid-debounce/mid-press aborts immediately.
//  - key_in passes through a 2-FF synchroniser -> ksync[9:0]; FSM sees only ksync (2-cycle delay).
//  - States: IDLE, DB_PRESS, PRESSED, DB_RELEASE, WAIT_CLEAR.
//  - IDLE: ksync!=0 -> candidate=ksync, counter=1, DB_PRESS. ksync==0 -> stay.
//  - DB_PRESS: ksync==candidate -> counter++; when counter reaches DEBOUNCE_CYCLES:
//      candidate one-hot -> d_out=candidate, key_valid=1, key_strobe=1 (that cycle only), PRESSED;
//      candidate not one-hot -> multi_err=1 (one cycle), WAIT_CLEAR; d_out stays 0.
//    ksync!=candidate: ksync==0 -> IDLE; else candidate=ksync, counter=1 (restart, stay).
//  - PRESSED: ksync==candidate -> hold. Any change (release, extra key, other key) -> counter=0,
//    DB_RELEASE; d_out/key_valid still held.
//  - DB_RELEASE: ksync==0 -> counter++; at DEBOUNCE_CYCLES -> d_out=0, key_valid=0, IDLE.
//    ksync!=0 -> counter=0, stay (bounce or second key: no new key until full release).
//  - WAIT_CLEAR: identical release debounce to DB_RELEASE with d_out already 0; exits to IDLE.
//  - Latency: raw key stable from edge N -> key_strobe/d_out valid at edge N+2+DEBOUNCE_CYCLES.
//    Release: d_out clears at edge N+2+DEBOUNCE_CYCLES after last raw high->low transition.
//  - Invariants: d_out is always 0 or one-hot; key_valid == |d_out; key_strobe and multi_err never
//    in same cycle; counter saturates at DEBOUNCE_CYCLES, never wraps.
//  - Key held indefinitely: one strobe only, no auto-repeat.
// STRUCTURE
//  - Package decimal_key_pkg: KEY_COUNT=10, state enum key_state_t, function is_onehot10().
//  - Sub-module key_sync: parameterised-width 2-FF synchroniser (clk, reset, async in, sync out).
//  - Top: key_sync instance + FSM + CNT_W counter + candidate register; all outputs registered.
// TESTING (DEBOUNCE_CYCLES=4)
//  1 Reset with key_in=10'h008 held -> all outputs 0 during reset; after release strobe 6 cycles later.
//  2 key_in=10'h020 clean from edge N -> key_strobe=1 at N+6 only, d_out=10'h020, key_valid=1.
//  3 key_in 10'h004 toggling 0/1 every 2 cycles for 12 cycles, then stable -> no strobe until 6
//    cycles after last toggle; exactly one strobe.
//  4 key_in=10'h011 stable -> multi_err pulse at N+6, d_out stays 0, no key_strobe.
//  5 key 7 accepted, then key_in=10'h0 with a 1-cycle glitch high -> d_out=10'h080 held until
//    6 cycles after glitch, then 0; no second strobe.
//  6 reset asserted mid-DB_PRESS (counter=2) -> next cycle all outputs 0, state IDLE, no strobe.

Source files
------------

// File: rtl/decimal_key_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decimal_key_pkg
// Description : Shared key count, debouncer state encoding and one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package decimal_key_pkg;

    localparam int KEY_COUNT = 10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_PRESSED    = 3'd2,
        ST_DB_RELEASE = 3'd3,
        ST_WAIT_CLEAR = 3'd4
    } key_state_t;

    // A non-zero vector is one-hot exactly when clearing its lowest set bit leaves zero.
    function automatic logic is_onehot10(input logic [KEY_COUNT-1:0] v);
        logic [KEY_COUNT-1:0] w_dec;
        w_dec = v - {{(KEY_COUNT-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & w_dec) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decimal_key_debouncer_key_sync.sv
`default_nettype none
// ============================================================================
// Module      : key_sync
// Description : Parameterised-width two-flop synchroniser for asynchronous lines.
// Revision    : 1.0 - initial release
// ============================================================================
module key_sync #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/decimal_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : decimal_key_debouncer
// Description : Synchronises and debounces 10 key lines into a clean one-hot
//               decimal vector with new-key strobe and multi-key rejection.
// Revision    : 1.0 - initial release
// ============================================================================
module decimal_key_debouncer
    import decimal_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KEY_COUNT-1:0] key_in,
    output logic [KEY_COUNT-1:0] d_out,
    output logic                 key_valid,
    output logic                 key_strobe,
    output logic                 multi_err
);

    localparam logic [CNT_W-1:0] c_DB  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [KEY_COUNT-1:0] w_ksync;
    key_state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [KEY_COUNT-1:0] r_cand,   w_cand_nxt;
    logic [KEY_COUNT-1:0] r_d_out,  w_d_out_nxt;
    logic                 r_valid;
    logic                 r_strobe, w_strobe_nxt;
    logic                 r_err,    w_err_nxt;

    key_sync #(
        .WIDTH (KEY_COUNT)
    ) u_key_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (key_in),
        .o_sync  (w_ksync)
    );

    assign w_cnt_inc = r_cnt + c_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_cand   <= '0;
            r_d_out  <= '0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cand   <= w_cand_nxt;
            r_d_out  <= w_d_out_nxt;
            r_valid  <= |w_d_out_nxt;
            r_strobe <= w_strobe_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Press and release both need DEBOUNCE_CYCLES consecutive qualifying samples,
    // the first of which is the sample that triggered the state change.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cand_nxt   = r_cand;
        w_d_out_nxt  = r_d_out;
        w_strobe_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ksync != '0) begin
                    w_cand_nxt  = w_ksync;
                    w_cnt_nxt   = c_ONE;
                    w_state_nxt = ST_DB_PRESS;
                end
            end
            ST_DB_PRESS: begin
                if (w_ksync == r_cand) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_DB) begin
                        if (is_onehot10(r_cand)) begin
                            w_d_out_nxt  = r_cand;
                            w_strobe_nxt = 1'b1;
                            w_state_nxt  = ST_PRESSED;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_WAIT_CLEAR;
                        end
                    end
                end else if (w_ksync == '0) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cand_nxt = w_ksync;
                    w_cnt_nxt  = c_ONE;
                end
            end
            ST_PRESSED: begin
                if (w_ksync != r_cand) begin
                    w_cnt_nxt   = (w_ksync == '0) ? c_ONE : '0;
                    w_state_nxt = ST_DB_RELEASE;
                end
            end
            ST_DB_RELEASE, ST_WAIT_CLEAR: begin
                if (w_ksync == '0) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_DB) begin
                        w_d_out_nxt = '0;
                        w_cand_nxt  = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_d_out_nxt = '0;
                w_cand_nxt  = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign d_out      = r_d_out;
    assign key_valid  = r_valid;
    assign key_strobe = r_strobe;
    assign multi_err  = r_err;

endmodule
`default_nettype wire
